// File: rtl/npu_wb_buffer.sv
// Write-back buffer: pairs datapath half-words into full words, queues them with bank/address,
// and drains them to the even/odd result memories. Error flags are built only with NPU_WB_ERR_EN.
module npu_wb_buffer #(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int AW    = 10,
    parameter int DEPTH = 4
) (
    input  logic                      ck,
    input  logic                      rst,
    input  logic                      in_wr,
    input  logic                      in_wrh_l_n,
    input  logic [N*W/2-1:0]          in_data,
    input  logic                      in_ev_odd_n,
    input  logic [AW-1:0]             in_even_addr,
    input  logic [AW-1:0]             in_odd_addr,
    input  logic                      even_ready,
    input  logic                      odd_ready,
    output logic                      even_we,
    output logic                      odd_we,
    output logic [AW-1:0]             even_addr,
    output logic [AW-1:0]             odd_addr,
    output logic [N*W-1:0]            even_wdata,
    output logic [N*W-1:0]            odd_wdata,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      empty,
    output logic                      err_ovf,
    output logic                      err_seq,
    input  logic                      err_clr
);
    localparam int HW = N*W/2;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    typedef enum logic {WAIT_HI, WAIT_LO} state_t;

    typedef struct packed {
        logic            bank;   // 1 = even
        logic [AW-1:0]   addr;
        logic [N*W-1:0]  word;
    } entry_t;

    state_t          state, state_nx;
    logic [HW-1:0]   up_data;
    logic            up_bank;
    logic [AW-1:0]   up_addr;
    logic            ld_hi, push, seq_err;

    entry_t          mem [DEPTH];
    entry_t          head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            has_head, full, pop, push_ok, ovf;

    always_comb begin
        state_nx = state;
        ld_hi    = 1'b0;
        push     = 1'b0;
        seq_err  = 1'b0;
        if (in_wr) begin
            case (state)
                WAIT_HI: begin
                    if (!in_wrh_l_n) begin
                        ld_hi    = 1'b1;
                        state_nx = WAIT_LO;
                    end else begin
                        seq_err = 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (in_wrh_l_n) begin
                        push     = 1'b1;
                        state_nx = WAIT_HI;
                    end else begin
                        // a second upper half restarts assembly rather than being dropped
                        seq_err = 1'b1;
                        ld_hi   = 1'b1;
                    end
                end
                default: state_nx = WAIT_HI;
            endcase
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            state   <= WAIT_HI;
            up_data <= '0;
            up_bank <= 1'b0;
            up_addr <= '0;
        end else begin
            state <= state_nx;
            if (ld_hi) begin
                up_data <= in_data;
                up_bank <= in_ev_odd_n;
                up_addr <= in_ev_odd_n ? in_even_addr : in_odd_addr;
            end
        end
    end

    assign head     = mem[rd_ptr];
    assign has_head = (level != '0);
    assign full     = (level == LW'(DEPTH));
    assign pop      = has_head && (head.bank ? even_ready : odd_ready);
    // a full FIFO still accepts a word when the head drains on the same edge
    assign push_ok  = push && (!full || pop);
    assign ovf      = push && full && !pop;

    always_ff @(posedge ck) begin
        if (push_ok)
            mem[wr_ptr] <= '{bank: up_bank, addr: up_addr, word: {up_data, in_data}};
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            level <= level + LW'(push_ok) - LW'(pop);
        end
    end

    assign even_we    = has_head &  head.bank;
    assign odd_we     = has_head & ~head.bank;
    assign even_addr  = even_we ? head.addr : '0;
    assign even_wdata = even_we ? head.word : '0;
    assign odd_addr   = odd_we  ? head.addr : '0;
    assign odd_wdata  = odd_we  ? head.word : '0;
    assign empty      = !has_head && (state == WAIT_HI);

`ifdef NPU_WB_ERR_EN
    // set beats clear when both land on the same edge
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            err_ovf <= 1'b0;
            err_seq <= 1'b0;
        end else begin
            err_ovf <= ovf     | (err_ovf & ~err_clr);
            err_seq <= seq_err | (err_seq & ~err_clr);
        end
    end
`else
    logic unused_err;
    assign unused_err = &{1'b0, err_clr, ovf, seq_err};
    assign err_ovf    = 1'b0;
    assign err_seq    = 1'b0;
`endif

endmodule

// File: tb/tb_npu_wb_buffer.sv
// Bench for npu_wb_buffer: vector table plus hand sequences, with a queue scoreboard of expected writes.
module tb_npu_wb_buffer;
    localparam int N = 4, W = 8, AW = 10, DEPTH = 4;
`ifdef NPU_WB_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic            ck = 1'b0, rst;
    logic            in_wr, in_wrh_l_n, in_ev_odd_n, even_ready, odd_ready, err_clr;
    logic [15:0]     in_data;
    logic [AW-1:0]   in_even_addr, in_odd_addr, even_addr, odd_addr;
    logic            even_we, odd_we, empty, err_ovf, err_seq;
    logic [31:0]     even_wdata, odd_wdata;
    logic [2:0]      level;

    npu_wb_buffer #(.N(N), .W(W), .AW(AW), .DEPTH(DEPTH)) dut (
        .ck(ck), .rst(rst), .in_wr(in_wr), .in_wrh_l_n(in_wrh_l_n), .in_data(in_data),
        .in_ev_odd_n(in_ev_odd_n), .in_even_addr(in_even_addr), .in_odd_addr(in_odd_addr),
        .even_ready(even_ready), .odd_ready(odd_ready), .even_we(even_we), .odd_we(odd_we),
        .even_addr(even_addr), .odd_addr(odd_addr), .even_wdata(even_wdata), .odd_wdata(odd_wdata),
        .level(level), .empty(empty), .err_ovf(err_ovf), .err_seq(err_seq), .err_clr(err_clr)
    );

    always #5 ck = ~ck;

    typedef struct {
        logic          bank;
        logic [AW-1:0] addr;
        logic [31:0]   word;
    } ent_t;

    typedef struct {
        logic wr, hl, ev, er, orr, clr;
        logic [15:0] d;
        logic [AW-1:0] ea, oa;
        int   exp_level;
        logic exp_ewe, exp_seq;
    } vec_t;

    ent_t          q[$];
    logic          m_lo, m_bank, m_ovf, m_seq;
    logic [15:0]   m_up;
    logic [AW-1:0] m_addr;
    int            checks = 0, errors = 0, n_wr = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_lo = 0; m_bank = 0; m_up = '0; m_addr = '0; m_ovf = 0; m_seq = 0;
    endtask

    // Drive one cycle at negedge, check outputs against the model, then advance the model at posedge.
    task automatic step(input logic wr, hl, input logic [15:0] d, input logic ev,
                        input logic [AW-1:0] ea, oa, input logic er, orr, clr);
        logic ewe_x, owe_x, pop, push, sq, ovf;
        in_wr = wr; in_wrh_l_n = hl; in_data = d; in_ev_odd_n = ev;
        in_even_addr = ea; in_odd_addr = oa; even_ready = er; odd_ready = orr; err_clr = clr;
        #1;
        ewe_x = (q.size() > 0) && q[0].bank;
        owe_x = (q.size() > 0) && !q[0].bank;
        chk("even_we", even_we, ewe_x);
        chk("odd_we", odd_we, owe_x);
        chk("level", level, q.size());
        chk("empty", empty, (q.size() == 0) && !m_lo);
        chk("err_ovf", err_ovf, m_ovf);
        chk("err_seq", err_seq, m_seq);
        if (ewe_x) chk("even_port", {even_addr, even_wdata}, {q[0].addr, q[0].word});
        else       chk("even_idle", {even_addr, even_wdata}, 0);
        if (owe_x) chk("odd_port", {odd_addr, odd_wdata}, {q[0].addr, q[0].word});
        else       chk("odd_idle", {odd_addr, odd_wdata}, 0);
        if ((even_we && er) || (odd_we && orr)) n_wr++;
        pop  = (ewe_x && er) || (owe_x && orr);
        push = wr && m_lo && hl;
        sq   = wr && (m_lo != hl);
        ovf  = push && (q.size() == DEPTH) && !pop;
        @(posedge ck);
        if (pop) void'(q.pop_front());
        if (push && !ovf) q.push_back('{bank: m_bank, addr: m_addr, word: {m_up, d}});
        if (wr && !hl) begin
            m_up = d; m_bank = ev; m_addr = ev ? ea : oa; m_lo = 1;
        end else if (push) m_lo = 0;
        if (ERR) begin
            m_ovf = ovf | (m_ovf & ~clr);
            m_seq = sq  | (m_seq & ~clr);
        end
        @(negedge ck);
    endtask

    task automatic idle(input logic er, orr, input int n);
        for (int i = 0; i < n; i++) step(0, 0, 16'h0, 0, '0, '0, er, orr, 0);
    endtask

    task automatic word(input logic ev, input logic [AW-1:0] a, input logic [31:0] w,
                        input logic er, orr);
        step(1, 0, w[31:16], ev, a, a, er, orr, 0);
        step(1, 1, w[15:0],  ev, a, a, er, orr, 0);
    endtask

    task automatic do_reset();
        rst = 1; in_wr = 0; err_clr = 0;
        #1;
        chk("rst_we", {even_we, odd_we}, 0);
        chk("rst_level", level, 0);
        chk("rst_empty", empty, 1);
        chk("rst_ports", {even_addr, odd_addr, even_wdata, odd_wdata}, 0);
        chk("rst_err", {err_ovf, err_seq}, 0);
        model_reset();
        @(negedge ck);
        rst = 0;
    endtask

    vec_t vt[12];
    int   base;

    initial begin
        rst = 1; in_wr = 0; in_wrh_l_n = 0; in_data = 0; in_ev_odd_n = 0;
        in_even_addr = 0; in_odd_addr = 0; even_ready = 0; odd_ready = 0; err_clr = 0;
        model_reset();
        @(negedge ck);
        do_reset();

        //           wr hl ev er orr clr  d         ea  oa  lvl ewe seq
        vt[0]  = '{1, 0, 1, 1, 0, 0, 16'hA1B2, 10'd5, 10'd0, 0, 0, 0};
        vt[1]  = '{1, 1, 1, 1, 0, 0, 16'hC3D4, 10'd0, 10'd0, 0, 0, 0};
        vt[2]  = '{0, 0, 0, 1, 0, 0, 16'h0,    10'd0, 10'd0, 1, 1, 0};
        vt[3]  = '{0, 0, 0, 1, 0, 0, 16'h0,    10'd0, 10'd0, 0, 0, 0};
        vt[4]  = '{1, 1, 0, 1, 0, 0, 16'h1111, 10'd0, 10'd0, 0, 0, 0};
        vt[5]  = '{0, 0, 0, 1, 0, 0, 16'h0,    10'd0, 10'd0, 0, 0, ERR};
        vt[6]  = '{0, 0, 0, 1, 0, 1, 16'h0,    10'd0, 10'd0, 0, 0, ERR};
        vt[7]  = '{0, 0, 0, 1, 0, 0, 16'h0,    10'd0, 10'd0, 0, 0, 0};
        vt[8]  = '{1, 1, 0, 1, 0, 1, 16'h2222, 10'd0, 10'd0, 0, 0, 0};
        vt[9]  = '{0, 0, 0, 1, 0, 0, 16'h0,    10'd0, 10'd0, 0, 0, ERR};
        vt[10] = '{0, 0, 0, 1, 0, 1, 16'h0,    10'd0, 10'd0, 0, 0, ERR};
        vt[11] = '{0, 0, 0, 1, 0, 0, 16'h0,    10'd0, 10'd0, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            in_wr = vt[i].wr; in_wrh_l_n = vt[i].hl; even_ready = vt[i].er;
            odd_ready = vt[i].orr; err_clr = vt[i].clr;
            #1;
            chk($sformatf("vec%0d_level", i), level, vt[i].exp_level);
            chk($sformatf("vec%0d_ewe", i), even_we, vt[i].exp_ewe);
            chk($sformatf("vec%0d_seq", i), err_seq, vt[i].exp_seq);
            if (vt[i].exp_ewe)
                chk("vec_word", {even_addr, even_wdata}, {10'd5, 32'hA1B2C3D4});
            step(vt[i].wr, vt[i].hl, vt[i].d, vt[i].ev, vt[i].ea, vt[i].oa,
                 vt[i].er, vt[i].orr, vt[i].clr);
        end

        // overflow: five words into a stalled odd bank
        base = n_wr;
        for (int i = 0; i < 5; i++) word(0, AW'(10 + i), 32'h5000_0000 + i, 0, 0);
        chk("ovf_level", level, 4);
        chk("ovf_flag", err_ovf, ERR);
        idle(0, 1, 6);
        chk("ovf_writes", n_wr - base, 4);

        // full FIFO with same-cycle pop and push
        step(0, 0, 16'h0, 0, '0, '0, 0, 0, 1);
        for (int i = 0; i < 4; i++) word(0, AW'(20 + i), 32'h6000_0000 + i, 0, 0);
        base = n_wr;
        step(1, 0, 16'h7777, 0, '0, 10'd30, 0, 0, 0);
        step(1, 1, 16'h8888, 0, '0, 10'd30, 0, 1, 0);
        chk("full_pp_level", level, 4);
        chk("full_pp_ovf", err_ovf, 0);
        chk("full_pp_writes", n_wr - base, 1);
        idle(0, 1, 5);

        // reset mid-word with two entries queued
        word(0, 10'd40, 32'h1234_5678, 0, 0);
        word(1, 10'd41, 32'h9ABC_DEF0, 0, 0);
        step(1, 0, 16'hDEAD, 1, 10'd42, 10'd0, 0, 0, 0);
        #2;
        do_reset();
        chk("post_rst_we", {even_we, odd_we}, 0);
        word(1, 10'd7, 32'hCAFE_F00D, 1, 1);
        base = n_wr;
        idle(1, 1, 2);
        chk("post_rst_write", n_wr - base, 1);

        // random mixed traffic
        for (int i = 0; i < 60; i++)
            step($urandom_range(0, 1), ($urandom_range(0, 3) != 0) ? m_lo : !m_lo,
                 16'($urandom), $urandom_range(0, 1), AW'($urandom), AW'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 1), ($urandom_range(0, 7) == 0));
        idle(1, 1, 6);
        chk("drain_level", level, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/npu_wb_buffer.md
NPU_WB_BUFFER -- requirements
Module: npu_wb_buffer

Interface
REQ-001 Parameter N, default 4: activation width in bits.
REQ-002 Parameter W, default 8: activations per memory word; a half-word holds W/2 activations.
REQ-003 Parameter AW, default 10: result-memory address width.
REQ-004 Parameter DEPTH, default 4, power of two >= 2: word FIFO depth.
REQ-005 ck  in  1  clock; all state updates on the rising edge; the design SHALL use one clock only.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 in_wr  in  1  half-word valid, from datapath o_data_wr.
REQ-008 in_wrh_l_n  in  1  half select: 0 = upper half (word bits [N*W-1:N*W/2]), 1 = lower half.
REQ-009 in_data  in  N*W/2  half-word payload; activation 0 in the MSBs.
REQ-010 in_ev_odd_n  in  1  target bank: 1 = even, 0 = odd.
REQ-011 in_even_addr, in_odd_addr  in  AW each  bank addresses, sampled with the upper half.
REQ-012 even_ready, odd_ready  in  1 each  bank accepts a write this cycle.
REQ-013 even_we, odd_we  out  1 each  bank write strobe.
REQ-014 even_addr, odd_addr  out  AW each; even_wdata, odd_wdata  out  N*W each.
REQ-015 level  out  clog2(DEPTH)+1  FIFO occupancy; empty  out  1  (level == 0) and no half pending.
REQ-016 err_ovf, err_seq  out  1 each  sticky error flags; err_clr  in  1  synchronous flag clear.

Function
REQ-017 Assembly FSM SHALL have states WAIT_HI and WAIT_LO; reset state WAIT_HI.
REQ-018 WAIT_HI, in_wr=1, in_wrh_l_n=0: latch in_data into upper half, latch bank select and the selected bank's address; go to WAIT_LO.
REQ-019 WAIT_HI, in_wr=1, in_wrh_l_n=1: discard the half, set err_seq, stay in WAIT_HI.
REQ-020 WAIT_LO, in_wr=1, in_wrh_l_n=1: form word {upper, in_data} and push it to the FIFO on the same edge; go to WAIT_HI.
REQ-021 WAIT_LO, in_wr=1, in_wrh_l_n=0: set err_seq, restart assembly with the new upper half, bank and address; stay in WAIT_LO.
REQ-022 in_wr=0: the FSM SHALL hold its state and latched data.
REQ-023 Each FIFO entry SHALL store {bank, addr, word}.
REQ-024 With the FIFO non-empty, the head entry SHALL drive its bank's we=1, addr and wdata; the other bank's we=0; wdata/addr of an idle bank SHALL be 0.
REQ-025 Pop occurs when the head's bank ready=1 while its we=1; otherwise the head holds stable.
REQ-026 Latency: a word completed at edge t SHALL appear on the memory port in cycle t+1 if the FIFO was empty.
REQ-027 Push and pop in the same cycle SHALL both succeed, including when full; level is unchanged.
REQ-028 Push when full without a same-cycle pop: drop the word, set err_ovf, keep FIFO contents.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH; level SHALL saturate at neither end beyond 0..DEPTH.
REQ-030 err_clr=1 clears both flags; an error event in the same cycle as err_clr SHALL win (flag set).

Reset
REQ-031 rst=1 SHALL immediately set FSM to WAIT_HI, pointers and level to 0, empty=1, both we=0, all addr/wdata=0, both error flags=0.
REQ-032 rst asserted mid-word or with a non-empty FIFO SHALL discard all pending data; no write strobe is issued after reset assertion.

Configuration
REQ-033 Macro NPU_WB_ERR_EN: when defined, err_ovf/err_seq/err_clr behave per REQ-019..REQ-030; when undefined, ports remain, err_ovf and err_seq are tied 0, err_clr is ignored, and all data behaviour is identical.

Verification
REQ-034 Reset, then upper 16'hA1B2 (even, addr 5), lower 16'hC3D4, even_ready=1 -> next cycle even_we=1, even_addr=5, even_wdata=32'hA1B2C3D4, level returns to 0.
REQ-035 odd_ready=0, five back-to-back words to odd bank, DEPTH=4 -> level=4, fifth word dropped, err_ovf=1; raise odd_ready -> four writes in order, no fifth.
REQ-036 Lower half first (in_wrh_l_n=1) from WAIT_HI -> no push, err_seq=1; err_clr pulse -> err_seq=0.
REQ-037 FIFO full, ready=1 and new word completes in the same cycle -> one write issued, new word accepted, level stays 4, err_ovf=0.
REQ-038 rst pulsed in WAIT_LO with 2 entries queued -> we=0 immediately, level=0, empty=1; subsequent clean word written correctly.
REQ-039 Build without NPU_WB_ERR_EN, repeat REQ-035/036 stimulus -> same writes, err flags stay 0.
